ifu: RTL

Instruction fetch unit for the MIPS core. It holds the program counter and fetches one word per instruction from an instruction memory over a req/ack handshake. It presents the latched instruction, whose `instr[15:0]` feeds the immediate extender and whose other fields feed the decoder. On each retire it computes the next PC: sequential, conditional branch, `j`/`jal`, or `jr`.

---
 rtl/ifu_pkg.sv | 22 ++
 rtl/ifu_npc.sv | 40 ++++
 rtl/ifu.sv | 103 ++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// +----------------------------------------------------------------------------+
// | ifu_pkg : shared encodings and constants for the instruction fetch unit    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package ifu_pkg;

  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [31:0] C_RESET_PC = 32'h0000_3000;

endpackage

`default_nettype wire

// File: rtl/ifu_npc.sv
// +----------------------------------------------------------------------------+
// | npc : combinational next-PC selection (seq / branch / jump / jr)           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module npc
  import ifu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [31:0] jr_target,
  output logic [31:0] npc
);

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_offset;
  logic        w_unused;

  assign w_pc_plus4  = pc + 32'd4;
  assign w_br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
  // Opcode bits and the byte offset of the jr register play no part in the target.
  assign w_unused    = ^{instr[31:26], jr_target[1:0]};

  always_comb begin
    npc = w_pc_plus4;
    case (npc_op)
      NPC_SEQ:    npc = w_pc_plus4;
      NPC_BRANCH: npc = br_taken ? (w_pc_plus4 + w_br_offset) : w_pc_plus4;
      NPC_JUMP:   npc = {w_pc_plus4[31:28], instr[25:0], 2'b00};
      NPC_JR:     npc = {jr_target[31:2], 2'b00};
      default:    npc = w_pc_plus4;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ifu.sv
// +----------------------------------------------------------------------------+
// | ifu : PC register, req/ack instruction fetch FSM and latched instruction   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        advance,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [31:0] jr_target
);

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic [31:0] w_npc;
  logic        w_req;
  logic        w_latch;
  logic        w_retire;

  npc u_npc (
    .pc        (r_pc),
    .instr     (r_instr),
    .npc_op    (npc_op),
    .br_taken  (br_taken),
    .jr_target (jr_target),
    .npc       (w_npc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = S_FETCH;
      S_FETCH: if (imem_ack) w_next_state = S_HOLD;
      S_HOLD:  if (advance)  w_next_state = S_FETCH;
      default: w_next_state = S_IDLE;
    endcase
  end

  // IDLE never requests, so an ack left over from a reset-aborted fetch is dropped.
  always_comb begin
    w_req    = 1'b0;
    w_latch  = 1'b0;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_req   = 1'b1;
        w_latch = imem_ack;
      end
      S_HOLD:  w_retire = advance;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_instr       <= 32'd0;
      r_instr_valid <= 1'b0;
    end else begin
      if (w_latch) begin
        r_instr       <= imem_rdata;
        r_instr_valid <= 1'b1;
      end
      if (w_retire) begin
        r_pc          <= w_npc;
        r_instr_valid <= 1'b0;
      end
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus4    = r_pc + 32'd4;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;

endmodule

`default_nettype wire
